// File: rtl/led_pkg.sv
// Shared types and default timing for the LED frame scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package led_pkg;

  localparam int BITS_PER_LED = 24;
  localparam int NUM_LEDS     = 6;
  localparam int FRAME_W      = BITS_PER_LED * NUM_LEDS;
  localparam int TIMER_W      = 32;

  // Defaults for a 24 MHz clock
  localparam int DEF_LATCH_CYCLES   = 1440;    // 60 us low time after a frame
  localparam int DEF_REFRESH_CYCLES = 480000;  // 20 ms frame-start to frame-start
  localparam int DEF_TIMEOUT_CYCLES = 8192;    // give up on drv_done after this
  localparam bit DEF_AUTO_REFRESH   = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    SEND  = 3'd2,
    LATCH = 3'd3,
    GAP   = 3'd4
  } sched_state_t;

  // Timers read 0 on their first counted cycle, so a span of N cycles ends at N-1.
  function automatic logic [TIMER_W-1:0] last_tick(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/led_interval_timer.sv
// Saturating up-counter that flags once it has reached a programmable terminal value.
// Latency: clear takes effect on the next cycle; expired is decoded directly from the count.
// Backpressure: none.
module led_interval_timer
  import led_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [TIMER_W-1:0] terminal,
  output logic               expired
);

  logic [TIMER_W-1:0] count;

  // Count every cycle and hold at the terminal value until cleared
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count < terminal) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign expired = (count >= terminal);

endmodule

// File: rtl/led_frame_scheduler.sv
// Feeds led_driver: captures frames, runs the reset/load/latch sequence, auto-refreshes the last frame.
// Latency: an accepted frame sits one PREP cycle on drv_rgb before drv_load rises.
// Backpressure: frame_ready only in IDLE/GAP; a frame held valid while busy waits for the next GAP.
module led_frame_scheduler
  import led_pkg::*;
#(
  parameter int LATCH_CYCLES   = DEF_LATCH_CYCLES,
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter bit AUTO_REFRESH   = DEF_AUTO_REFRESH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_valid,
  input  logic [FRAME_W-1:0] frame_data,
  output logic               frame_ready,
  input  logic               blank,
  input  logic               drv_done,
  output logic [FRAME_W-1:0] drv_rgb,
  output logic               drv_rst,
  output logic               drv_load,
  output logic               drv_rst_leds,
  output logic               busy,
  output logic               timeout_err,
  output logic [15:0]        frame_count
);

  sched_state_t       state, next_state;
  logic [FRAME_W-1:0] stored_frame;
  logic               blank_q;
  logic               accept;
  logic               blank_rise;
  logic               start_refresh;
  logic               latch_done;
  logic               refresh_expired;
  logic               send_timeout;

  // Ready is decoded from the state register alone, never from frame_valid
  assign frame_ready   = !rst && (state == IDLE || state == GAP);
  assign accept        = frame_valid && frame_ready;
  assign blank_rise    = blank && !blank_q;
  // A new frame beats a refresh in the same GAP cycle
  assign start_refresh = (state == GAP) && !accept &&
                         ((AUTO_REFRESH && refresh_expired) || blank_rise);

  // Latch span: held clear outside LATCH so it reads 0 on the first LATCH cycle
  led_interval_timer u_latch_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state != LATCH),
    .terminal (last_tick(LATCH_CYCLES)),
    .expired  (latch_done)
  );

  // SEND watchdog: same scheme, live only while SEND
  led_interval_timer u_timeout_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state != SEND),
    .terminal (last_tick(TIMEOUT_CYCLES)),
    .expired  (send_timeout)
  );

  // Refresh period: zeroed as PREP is entered so PREP-to-PREP is exactly REFRESH_CYCLES
  led_interval_timer u_refresh_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (next_state == PREP),
    .terminal (last_tick(REFRESH_CYCLES)),
    .expired  (refresh_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and driver control decode
  always_comb begin
    next_state   = state;
    drv_rst      = rst;
    drv_load     = 1'b0;
    drv_rst_leds = 1'b1;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        if (accept) next_state = PREP;
      end
      PREP: begin
        drv_rst    = 1'b1;
        busy       = 1'b1;
        next_state = SEND;
      end
      SEND: begin
        drv_load     = !rst;
        drv_rst_leds = rst;
        busy         = 1'b1;
        if (drv_done || send_timeout) next_state = LATCH;
      end
      LATCH: begin
        busy = 1'b1;
        if (latch_done) next_state = GAP;
      end
      GAP: begin
        if (accept || start_refresh) next_state = PREP;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Frame capture; drv_rgb only moves on the cycle that launches PREP
  always_ff @(posedge clk) begin
    if (rst) begin
      stored_frame <= '0;
      drv_rgb      <= '0;
    end else if (accept) begin
      stored_frame <= frame_data;
      drv_rgb      <= blank ? '0 : frame_data;
    end else if (start_refresh) begin
      drv_rgb      <= blank ? '0 : stored_frame;
    end
  end

  // Blank edge detector
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank;
    end
  end

  // Completion counter and sticky timeout flag; done beats a coincident timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
      timeout_err <= 1'b0;
    end else if (state == SEND) begin
      if (drv_done) begin
        frame_count <= frame_count + 16'd1;
      end else if (send_timeout) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler with shortened timing.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_frame_scheduler;
  import led_pkg::*;

  localparam int L = 6;
  localparam int T = 20;
  localparam int R = 60;

  localparam logic [FRAME_W-1:0] F1  = {3{48'hFFFFFF_000000}};
  localparam logic [FRAME_W-1:0] F2  = {6{24'h00FF00}};
  localparam logic [FRAME_W-1:0] F3  = {6{24'h123456}};
  localparam logic [FRAME_W-1:0] FA5 = {18{8'hA5}};
  localparam logic [FRAME_W-1:0] FB  = {9{16'h0F0F}};
  localparam logic [FRAME_W-1:0] FC  = {6{24'hC0FFEE}};
  localparam logic [FRAME_W-1:0] FD  = {6{24'h00BEEF}};
  localparam logic [FRAME_W-1:0] FE  = {6{24'h5A5A5A}};
  localparam logic [FRAME_W-1:0] Z   = '0;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               frame_valid = 1'b0;
  logic [FRAME_W-1:0] frame_data = '0;
  logic               blank = 1'b0;
  logic               drv_done = 1'b0;
  logic               frame_ready, drv_rst, drv_load, drv_rst_leds, busy, timeout_err;
  logic [FRAME_W-1:0] drv_rgb;
  logic [15:0]        frame_count;

  logic               nr_valid = 1'b0;
  logic [FRAME_W-1:0] nr_data = '0;
  logic               nr_done = 1'b0;
  logic               nr_ready, nr_rst, nr_load, nr_rst_leds, nr_busy, nr_terr;
  logic [FRAME_W-1:0] nr_rgb;
  logic [15:0]        nr_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_prep = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_frame_scheduler #(
    .LATCH_CYCLES(L), .REFRESH_CYCLES(R), .TIMEOUT_CYCLES(T), .AUTO_REFRESH(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_data(frame_data),
    .frame_ready(frame_ready), .blank(blank), .drv_done(drv_done), .drv_rgb(drv_rgb),
    .drv_rst(drv_rst), .drv_load(drv_load), .drv_rst_leds(drv_rst_leds), .busy(busy),
    .timeout_err(timeout_err), .frame_count(frame_count)
  );

  led_frame_scheduler #(
    .LATCH_CYCLES(L), .REFRESH_CYCLES(R), .TIMEOUT_CYCLES(T), .AUTO_REFRESH(1'b0)
  ) dut_nr (
    .clk(clk), .rst(rst), .frame_valid(nr_valid), .frame_data(nr_data),
    .frame_ready(nr_ready), .blank(1'b0), .drv_done(nr_done), .drv_rgb(nr_rgb),
    .drv_rst(nr_rst), .drv_load(nr_load), .drv_rst_leds(nr_rst_leds), .busy(nr_busy),
    .timeout_err(nr_terr), .frame_count(nr_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame from its PREP cycle to the first non-busy cycle; done_mask bit n pulses drv_done n cycles after PREP.
  task automatic run_frame(input logic [63:0] done_mask, input logic [FRAME_W-1:0] exp_rgb,
                           output int len, output int send_len, output int latch_len,
                           output int rgb_bad, output int rdy_bad);
    len = 0; send_len = 0; latch_len = 0; rgb_bad = 0; rdy_bad = 0;
    while (busy && len < 500) begin
      drv_done = (len < 64) ? done_mask[len[5:0]] : 1'b0;
      if (drv_load) send_len++;
      if (drv_rst_leds && !drv_rst) latch_len++;
      if (drv_rgb !== exp_rgb) rgb_bad++;
      if (frame_ready) rdy_bad++;
      tick();
      len++;
    end
    drv_done = 1'b0;
  endtask

  task automatic wait_refresh(output int gap);
    int n;
    n = 0;
    while (!drv_rst && n < 200) begin
      tick();
      n++;
    end
    gap = cyc - t_prep;
  endtask

  task automatic test_reset();
    tick(); tick();
    vectors++;
    if ({frame_ready, drv_rst, drv_load, drv_rst_leds, busy, timeout_err} !== 6'b010100) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 010100",
               {frame_ready, drv_rst, drv_load, drv_rst_leds, busy, timeout_err});
    end
    vectors++;
    if (frame_count !== 16'd0 || drv_rgb !== Z) begin
      miscompares++;
      $display("FAIL reset_data: count %h rgb %h want 0", frame_count, drv_rgb);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if ({frame_ready, drv_rst, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL idle_ctrl: got %b want 100", {frame_ready, drv_rst, busy});
    end
  endtask

  task automatic test_no_refresh();
    int rst_seen, load_seen;
    nr_valid = 1'b1; nr_data = F1;
    tick();
    nr_valid = 1'b0;
    vectors++;
    if (nr_rst !== 1'b1 || nr_busy !== 1'b1 || nr_rgb !== F1 || nr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL nr_prep: rst %b busy %b ready %b rgb %h", nr_rst, nr_busy, nr_ready, nr_rgb);
    end
    tick();
    nr_done = 1'b1;
    tick();
    nr_done = 1'b0;
    rst_seen = 0; load_seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (nr_rst) rst_seen++;
      if (nr_load || !nr_rst_leds) load_seen++;
      tick();
    end
    vectors++;
    if (rst_seen != 0 || load_seen != 0) begin
      miscompares++;
      $display("FAIL nr_resend: prep cycles %0d send cycles %0d want 0 0", rst_seen, load_seen);
    end
    vectors++;
    if (nr_count !== 16'd1 || nr_terr !== 1'b0 || nr_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL nr_end: count %0d terr %b busy %b want 1 0 0", nr_count, nr_terr, nr_busy);
    end
  endtask

  task automatic test_single_frame();
    int len, sl, ll, rb, qb;
    frame_valid = 1'b1; frame_data = F1;
    vectors++;
    if (frame_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL first_ready: got %b want 1", frame_ready);
    end
    tick();
    frame_valid = 1'b0;
    frame_data = {$urandom(), $urandom(), $urandom(), $urandom(), 16'h5A5A};
    vectors++;
    if ({drv_rst, drv_load, busy, frame_ready} !== 4'b1010 || drv_rgb !== F1) begin
      miscompares++;
      $display("FAIL prep: ctrl %b want 1010 rgb %h", {drv_rst, drv_load, busy, frame_ready}, drv_rgb);
    end
    run_frame(64'h10, F1, len, sl, ll, rb, qb);
    vectors++;
    if (len != 11 || sl != 4 || ll != L || rb != 0) begin
      miscompares++;
      $display("FAIL single_seq: len %0d send %0d latch %0d rgb_bad %0d want 11 4 %0d 0", len, sl, ll, rb, L);
    end
    vectors++;
    if (frame_count !== 16'd1 || frame_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_gap: count %0d ready %b busy %b want 1 1 0", frame_count, frame_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    int len, sl, ll, rb, qb;
    frame_valid = 1'b1; frame_data = F2;
    tick();
    frame_data = F3;
    run_frame(64'h8, F2, len, sl, ll, rb, qb);
    vectors++;
    if (len != 10 || rb != 0 || qb != 0) begin
      miscompares++;
      $display("FAIL held_busy: len %0d rgb_bad %0d ready_bad %0d want 10 0 0", len, rb, qb);
    end
    vectors++;
    if (frame_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL held_gap_ready: got %b want 1", frame_ready);
    end
    tick();
    frame_valid = 1'b0;
    t_prep = cyc;
    vectors++;
    if (drv_rst !== 1'b1 || drv_rgb !== F3) begin
      miscompares++;
      $display("FAIL held_accept: rst %b rgb %h want 1 %h", drv_rst, drv_rgb, F3);
    end
    run_frame(64'h4, F3, len, sl, ll, rb, qb);
    vectors++;
    if (frame_count !== 16'd3 || rb != 0) begin
      miscompares++;
      $display("FAIL held_count: count %0d rgb_bad %0d want 3 0", frame_count, rb);
    end
  endtask

  task automatic test_auto_refresh();
    int gap, len, sl, ll, rb, qb;
    wait_refresh(gap);
    vectors++;
    if (gap != R || drv_rgb !== F3) begin
      miscompares++;
      $display("FAIL refresh: period %0d want %0d rgb %h", gap, R, drv_rgb);
    end
    run_frame(64'h2, F3, len, sl, ll, rb, qb);
    vectors++;
    if (frame_count !== 16'd4 || len != 8) begin
      miscompares++;
      $display("FAIL refresh_count: count %0d len %0d want 4 8", frame_count, len);
    end
  endtask

  task automatic test_blank();
    int gap, len, sl, ll, rb, qb;
    frame_valid = 1'b1; frame_data = FA5;
    tick();
    frame_valid = 1'b0;
    run_frame(64'h4, FA5, len, sl, ll, rb, qb);
    blank = 1'b1;
    tick();
    t_prep = cyc;
    vectors++;
    if (drv_rst !== 1'b1 || drv_rgb !== Z) begin
      miscompares++;
      $display("FAIL blank_rise: rst %b rgb %h want 1 0", drv_rst, drv_rgb);
    end
    run_frame(64'h4, Z, len, sl, ll, rb, qb);
    wait_refresh(gap);
    t_prep = cyc;
    vectors++;
    if (gap != R || drv_rgb !== Z) begin
      miscompares++;
      $display("FAIL blank_refresh: period %0d rgb %h want %0d 0", gap, drv_rgb, R);
    end
    run_frame(64'h2, Z, len, sl, ll, rb, qb);
    blank = 1'b0;
    wait_refresh(gap);
    vectors++;
    if (gap != R || drv_rgb !== FA5) begin
      miscompares++;
      $display("FAIL unblank_refresh: period %0d rgb %h want %0d %h", gap, drv_rgb, R, FA5);
    end
    run_frame(64'h2, FA5, len, sl, ll, rb, qb);
    vectors++;
    if (frame_count !== 16'd8) begin
      miscompares++;
      $display("FAIL blank_count: got %0d want 8", frame_count);
    end
  endtask

  task automatic test_done_edges();
    int len, sl, ll, rb, qb;
    frame_valid = 1'b1; frame_data = FB;
    tick();
    frame_valid = 1'b0;
    run_frame(64'h49, FB, len, sl, ll, rb, qb);
    vectors++;
    if (frame_count !== 16'd9 || len != 10 || ll != L) begin
      miscompares++;
      $display("FAIL stray_done: count %0d len %0d latch %0d want 9 10 %0d", frame_count, len, ll, L);
    end
    frame_valid = 1'b1; frame_data = FC;
    tick();
    frame_valid = 1'b0;
    run_frame(64'h1 << T, FC, len, sl, ll, rb, qb);
    vectors++;
    if (sl != T || frame_count !== 16'd10 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL done_at_timeout: send %0d count %0d terr %b want %0d 10 0", sl, frame_count, timeout_err, T);
    end
  endtask

  task automatic test_timeout();
    int len, sl, ll, rb, qb;
    frame_valid = 1'b1; frame_data = FD;
    tick();
    frame_valid = 1'b0;
    run_frame(64'h0, FD, len, sl, ll, rb, qb);
    vectors++;
    if (sl != T || ll != L || len != 1 + T + L) begin
      miscompares++;
      $display("FAIL timeout_seq: send %0d latch %0d len %0d want %0d %0d %0d", sl, ll, len, T, L, 1 + T + L);
    end
    vectors++;
    if (timeout_err !== 1'b1 || frame_count !== 16'd10) begin
      miscompares++;
      $display("FAIL timeout_flag: terr %b count %0d want 1 10", timeout_err, frame_count);
    end
    frame_valid = 1'b1; frame_data = FE;
    tick();
    frame_valid = 1'b0;
    run_frame(64'h4, FE, len, sl, ll, rb, qb);
    vectors++;
    if (timeout_err !== 1'b1 || frame_count !== 16'd11) begin
      miscompares++;
      $display("FAIL timeout_sticky: terr %b count %0d want 1 11", timeout_err, frame_count);
    end
  endtask

  task automatic test_reset_mid_send();
    int len, sl, ll, rb, qb;
    frame_valid = 1'b1; frame_data = F1;
    tick();
    frame_valid = 1'b0;
    tick(); tick();
    vectors++;
    if (drv_load !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_send: load %b want 1", drv_load);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({drv_rst, drv_load, frame_ready, drv_rst_leds} !== 4'b1001) begin
      miscompares++;
      $display("FAIL rst_async_view: got %b want 1001", {drv_rst, drv_load, frame_ready, drv_rst_leds});
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || drv_rst !== 1'b1 || frame_count !== 16'd0 || timeout_err !== 1'b0 || drv_rgb !== Z) begin
      miscompares++;
      $display("FAIL rst_applied: busy %b rst %b count %0d terr %b rgb %h", busy, drv_rst, frame_count, timeout_err, drv_rgb);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if ({frame_ready, drv_rst, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL rst_idle: got %b want 100", {frame_ready, drv_rst, busy});
    end
    frame_valid = 1'b1; frame_data = F2;
    tick();
    frame_valid = 1'b0;
    run_frame(64'h4, F2, len, sl, ll, rb, qb);
    vectors++;
    if (frame_count !== 16'd1 || rb != 0) begin
      miscompares++;
      $display("FAIL post_rst_frame: count %0d rgb_bad %0d want 1 0", frame_count, rb);
    end
  endtask

  initial begin
    test_reset();
    test_no_refresh();
    test_single_frame();
    test_back_to_back();
    test_auto_refresh();
    test_blank();
    test_done_edges();
    test_timeout();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
